// File: rtl/round_controller.sv
`default_nettype none
// round_controller - two-player quiz round sequencer: joystick sync/debounce, press arbitration,
// judging, scoring and game-end detection.  Revision 1.0
module round_controller #(
   parameter int NUM_Q        = 11,
   parameter int WIN_SCORE    = 5,
   parameter int DEBOUNCE_CYC = 4,
   parameter int FEEDBACK_CYC = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] joy_l,
   input  logic [3:0] joy_r,
   input  logic [2:0] q_ans,
   output logic [3:0] q_idx,
   output logic [2:0] score_l,
   output logic [2:0] score_r,
   output logic [1:0] feedback,
   output logic       lock_l,
   output logic       lock_r,
   output logic       game_over,
   output logic [1:0] winner
);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int FW = $clog2(FEEDBACK_CYC + 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYC);
   localparam logic [FW-1:0] FB_LAST = FW'(FEEDBACK_CYC - 1);
   localparam logic [3:0]    Q_LAST  = 4'(NUM_Q - 1);
   localparam logic [2:0]    WIN     = 3'(WIN_SCORE);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ASK   = 3'd1;
   localparam logic [2:0] S_JUDGE = 3'd2;
   localparam logic [2:0] S_SHOW  = 3'd3;
   localparam logic [2:0] S_NEXT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [1:0][3:0] joy;
   logic [1:0][2:0] code;
   logic [1:0]      acc;

   assign joy = {joy_r, joy_l};

   for (genvar p = 0; p < 2; p++) begin : g_player
      logic [3:0]    sync1_q, sync2_q;
      logic [2:0]    dec, last_q;
      logic [DW-1:0] cnt_q, cnt_d;
      logic          armed_q;

      always_comb begin
         case (sync2_q)
            4'b1110: dec = 3'd1;
            4'b1101: dec = 3'd2;
            4'b1011: dec = 3'd3;
            4'b0111: dec = 3'd4;
            default: dec = 3'd0;
         endcase
      end

      // Run length of the current valid code, saturating once it qualifies.
      always_comb begin
         cnt_d = '0;
         if (dec != 3'd0) begin
            if (dec != last_q)        cnt_d = DW'(1);
            else if (cnt_q != DEB_MAX) cnt_d = cnt_q + 1'b1;
            else                       cnt_d = cnt_q;
         end
      end

      assign acc[p]  = armed_q && (dec != 3'd0) && (cnt_d == DEB_MAX);
      assign code[p] = dec;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            last_q  <= 3'd0;
            cnt_q   <= '0;
            armed_q <= 1'b1;
         end else begin
            sync1_q <= joy[p];
            sync2_q <= sync1_q;
            last_q  <= dec;
            cnt_q   <= cnt_d;
            if (sync2_q == 4'hF) armed_q <= 1'b1;
            else if (acc[p])     armed_q <= 1'b0;
         end
      end
   end

   logic [2:0]    state_q, state_d;
   logic [3:0]    q_idx_q, q_idx_d;
   logic [2:0]    score_l_q, score_l_d, score_r_q, score_r_d;
   logic          lock_l_q, lock_l_d, lock_r_q, lock_r_d;
   logic [1:0]    fb_q, fb_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          side_q, side_d;
   logic [2:0]    code_q, code_d;
   logic          prio_q, prio_d;
   logic          take_l, take_r, ans_ok;

   assign take_l = acc[0] && !lock_l_q;
   assign take_r = acc[1] && !lock_r_q;
   assign ans_ok = (q_ans >= 3'd1) && (q_ans <= 3'd4);

   always_comb begin
      state_d   = state_q;
      q_idx_d   = q_idx_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      lock_l_d  = lock_l_q;
      lock_r_d  = lock_r_q;
      fb_d      = fb_q;
      fcnt_d    = fcnt_q;
      side_d    = side_q;
      code_d    = code_q;
      prio_d    = prio_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_ASK;
               q_idx_d   = 4'd0;
               score_l_d = 3'd0;
               score_r_d = 3'd0;
               lock_l_d  = 1'b0;
               lock_r_d  = 1'b0;
               fb_d      = 2'b00;
            end
         end
         S_ASK: begin
            if (!ans_ok) begin
               state_d = S_NEXT;
            end else if (take_l || take_r) begin
               state_d = S_JUDGE;
               // prio_q = 0 favours left on a same-cycle tie
               if (take_l && take_r) begin
                  side_d = prio_q;
                  prio_d = !prio_q;
               end else begin
                  side_d = take_r;
               end
               code_d = side_d ? code[1] : code[0];
            end
         end
         S_JUDGE: begin
            state_d = S_SHOW;
            fcnt_d  = '0;
            if (code_q == q_ans) begin
               fb_d = 2'b01;
               if (!side_q) score_l_d = (score_l_q == WIN) ? WIN : score_l_q + 1'b1;
               else         score_r_d = (score_r_q == WIN) ? WIN : score_r_q + 1'b1;
            end else begin
               fb_d = 2'b10;
               if (!side_q) lock_l_d = 1'b1;
               else         lock_r_d = 1'b1;
            end
         end
         S_SHOW: begin
            if (fcnt_q == FB_LAST) begin
               fb_d = 2'b00;
               if (fb_q == 2'b01 || (lock_l_q && lock_r_q)) state_d = S_NEXT;
               else                                         state_d = S_ASK;
            end else begin
               fcnt_d = fcnt_q + 1'b1;
            end
         end
         S_NEXT: begin
            lock_l_d = 1'b0;
            lock_r_d = 1'b0;
            if (score_l_q == WIN || score_r_q == WIN || q_idx_q == Q_LAST) begin
               state_d = S_DONE;
            end else begin
               q_idx_d = q_idx_q + 1'b1;
               state_d = S_ASK;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         q_idx_q   <= 4'd0;
         score_l_q <= 3'd0;
         score_r_q <= 3'd0;
         lock_l_q  <= 1'b0;
         lock_r_q  <= 1'b0;
         fb_q      <= 2'b00;
         fcnt_q    <= '0;
         side_q    <= 1'b0;
         code_q    <= 3'd0;
         prio_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         q_idx_q   <= q_idx_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         lock_l_q  <= lock_l_d;
         lock_r_q  <= lock_r_d;
         fb_q      <= fb_d;
         fcnt_q    <= fcnt_d;
         side_q    <= side_d;
         code_q    <= code_d;
         prio_q    <= prio_d;
      end
   end

   always_comb begin
      winner = 2'b00;
      if (state_q == S_DONE) begin
         if (score_l_q > score_r_q)      winner = 2'b01;
         else if (score_l_q < score_r_q) winner = 2'b10;
         else                            winner = 2'b11;
      end
   end

   assign game_over = (state_q == S_DONE);
   assign q_idx     = q_idx_q;
   assign score_l   = score_l_q;
   assign score_r   = score_r_q;
   assign feedback  = fb_q;
   assign lock_l    = lock_l_q;
   assign lock_r    = lock_r_q;
endmodule
`default_nettype wire

// File: tb/tb_round_controller.sv
`default_nettype none
`timescale 1ns/1ps
// tb_round_controller - table-driven game plus hand sequences; judgements checked via a scoreboard.
module tb_round_controller;
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] joy_l = 4'hF;
   logic [3:0] joy_r = 4'hF;
   logic [2:0] q_ans = 3'd1;
   logic [3:0] q_idx;
   logic [2:0] score_l, score_r;
   logic [1:0] feedback, winner;
   logic       lock_l, lock_r, game_over;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [1:0] fb;
      logic [2:0] sl;
      logic [2:0] sr;
      logic       ll;
      logic       lr;
   } exp_t;

   typedef struct {
      logic [2:0] qa;
      logic [2:0] cl;
      logic [2:0] cr;
      exp_t       e;
      logic [3:0] qi;
      logic       ll_a;
      logic       lr_a;
      logic       go;
   } vec_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   round_controller dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .joy_l    (joy_l),
      .joy_r    (joy_r),
      .q_ans    (q_ans),
      .q_idx    (q_idx),
      .score_l  (score_l),
      .score_r  (score_r),
      .feedback (feedback),
      .lock_l   (lock_l),
      .lock_r   (lock_r),
      .game_over(game_over),
      .winner   (winner)
   );

   function automatic logic [3:0] enc(input logic [2:0] c);
      case (c)
         3'd1:    return 4'b1110;
         3'd2:    return 4'b1101;
         3'd3:    return 4'b1011;
         3'd4:    return 4'b0111;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic exp_t mk_e(input logic [1:0] fb, input logic [2:0] sl, input logic [2:0] sr,
                                 input logic ll, input logic lr);
      exp_t e;
      e.fb = fb; e.sl = sl; e.sr = sr; e.ll = ll; e.lr = lr;
      return e;
   endfunction

   function automatic vec_t mk_v(input logic [2:0] qa, input logic [2:0] cl, input logic [2:0] cr,
                                 input exp_t e, input logic [3:0] qi, input logic lla,
                                 input logic lra, input logic go);
      vec_t v;
      v.qa = qa; v.cl = cl; v.cr = cr; v.e = e; v.qi = qi; v.ll_a = lla; v.lr_a = lra; v.go = go;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_fb(output bit seen, output int n);
      seen = 1'b0;
      n    = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (feedback != 2'b00) begin
            seen = 1'b1;
            n    = k;
            break;
         end
      end
      if (!seen) begin
         n_chk++;
         n_fail++;
         $display("FAIL fb_timeout: actual no feedback in 40 cycles, required feedback");
      end
   endtask

   // Hold codes until judged, release, then ride out SHOW and land back in ASK/DONE.
   task automatic press(input logic [2:0] cl, input logic [2:0] cr);
      bit seen;
      int n;
      int dur;
      joy_l = enc(cl);
      joy_r = enc(cr);
      wait_fb(seen, n);
      joy_l = 4'hF;
      joy_r = 4'hF;
      if (seen) begin
         chk("fb_latency", 32'(n), 32'd8);
         dur = 1;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (feedback == 2'b00) break;
            dur++;
         end
         chk("fb_duration", 32'(dur), 32'd8);
      end
      tick(3);
   endtask

   logic [1:0] fb_prev = 2'b00;
   always @(negedge clk) begin
      exp_t e;
      if (feedback != 2'b00 && fb_prev == 2'b00) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_fb", 32'(feedback), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_feedback", 32'(feedback), 32'(e.fb));
            chk("sb_score_l", 32'(score_l), 32'(e.sl));
            chk("sb_score_r", 32'(score_r), 32'(e.sr));
            chk("sb_lock_l", 32'(lock_l), 32'(e.ll));
            chk("sb_lock_r", 32'(lock_r), 32'(e.lr));
         end
      end
      fb_prev = feedback;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl [11];
      bit   seen;
      int   n;

      tbl[0]  = mk_v(3'd2, 3'd2, 3'd0, mk_e(2'b01, 3'd1, 3'd0, 1'b0, 1'b0), 4'd1, 1'b0, 1'b0, 1'b0);
      tbl[1]  = mk_v(3'd3, 3'd1, 3'd0, mk_e(2'b10, 3'd1, 3'd0, 1'b1, 1'b0), 4'd1, 1'b1, 1'b0, 1'b0);
      tbl[2]  = mk_v(3'd3, 3'd0, 3'd3, mk_e(2'b01, 3'd1, 3'd1, 1'b1, 1'b0), 4'd2, 1'b0, 1'b0, 1'b0);
      tbl[3]  = mk_v(3'd4, 3'd4, 3'd4, mk_e(2'b01, 3'd2, 3'd1, 1'b0, 1'b0), 4'd3, 1'b0, 1'b0, 1'b0);
      tbl[4]  = mk_v(3'd1, 3'd1, 3'd1, mk_e(2'b01, 3'd2, 3'd2, 1'b0, 1'b0), 4'd4, 1'b0, 1'b0, 1'b0);
      tbl[5]  = mk_v(3'd0, 3'd0, 3'd0, mk_e(2'b00, 3'd2, 3'd2, 1'b0, 1'b0), 4'd5, 1'b0, 1'b0, 1'b0);
      tbl[6]  = mk_v(3'd1, 3'd2, 3'd0, mk_e(2'b10, 3'd2, 3'd2, 1'b1, 1'b0), 4'd5, 1'b1, 1'b0, 1'b0);
      tbl[7]  = mk_v(3'd1, 3'd0, 3'd3, mk_e(2'b10, 3'd2, 3'd2, 1'b1, 1'b1), 4'd6, 1'b0, 1'b0, 1'b0);
      tbl[8]  = mk_v(3'd3, 3'd3, 3'd0, mk_e(2'b01, 3'd3, 3'd2, 1'b0, 1'b0), 4'd7, 1'b0, 1'b0, 1'b0);
      tbl[9]  = mk_v(3'd3, 3'd3, 3'd0, mk_e(2'b01, 3'd4, 3'd2, 1'b0, 1'b0), 4'd8, 1'b0, 1'b0, 1'b0);
      tbl[10] = mk_v(3'd3, 3'd3, 3'd0, mk_e(2'b01, 3'd5, 3'd2, 1'b0, 1'b0), 4'd8, 1'b0, 1'b0, 1'b1);

      tick(3);
      chk("rst_q_idx", 32'(q_idx), 32'd0);
      chk("rst_scores", 32'({score_l, score_r}), 32'd0);
      chk("rst_feedback", 32'(feedback), 32'd0);
      chk("rst_locks", 32'({lock_l, lock_r}), 32'd0);
      chk("rst_game_over", 32'(game_over), 32'd0);
      chk("rst_winner", 32'(winner), 32'd0);
      rst_n = 1'b1;
      tick(3);
      pulse_start();

      for (int i = 0; i < 11; i++) begin
         q_ans = tbl[i].qa;
         if (tbl[i].e.fb == 2'b00) begin
            tick(1);
            q_ans = 3'd1;
            tick(3);
            chk("skip_score_l", 32'(score_l), 32'(tbl[i].e.sl));
            chk("skip_score_r", 32'(score_r), 32'(tbl[i].e.sr));
         end else begin
            sb.push_back(tbl[i].e);
            press(tbl[i].cl, tbl[i].cr);
         end
         chk("vec_q_idx", 32'(q_idx), 32'(tbl[i].qi));
         chk("vec_lock_l", 32'(lock_l), 32'(tbl[i].ll_a));
         chk("vec_lock_r", 32'(lock_r), 32'(tbl[i].lr_a));
         chk("vec_game_over", 32'(game_over), 32'(tbl[i].go));
      end
      chk("done_winner_left", 32'(winner), 32'd1);

      // Restart from DONE.
      pulse_start();
      chk("restart_q_idx", 32'(q_idx), 32'd0);
      chk("restart_scores", 32'({score_l, score_r}), 32'd0);
      chk("restart_game_over", 32'(game_over), 32'd0);
      chk("restart_winner", 32'(winner), 32'd0);

      // start is ignored mid-game.
      q_ans = 3'd1;
      sb.push_back(mk_e(2'b01, 3'd1, 3'd0, 1'b0, 1'b0));
      press(3'd1, 3'd0);
      chk("ign_q_idx_before", 32'(q_idx), 32'd1);
      pulse_start();
      tick(2);
      chk("ign_start_q_idx", 32'(q_idx), 32'd1);
      chk("ign_start_score_l", 32'(score_l), 32'd1);

      // Asynchronous reset in SHOW while the left joystick stays held.
      q_ans = 3'd2;
      sb.push_back(mk_e(2'b01, 3'd2, 3'd0, 1'b0, 1'b0));
      joy_l = enc(3'd2);
      wait_fb(seen, n);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_feedback", 32'(feedback), 32'd0);
      chk("async_rst_score_l", 32'(score_l), 32'd0);
      chk("async_rst_q_idx", 32'(q_idx), 32'd0);
      chk("async_rst_game_over", 32'(game_over), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(12);
      pulse_start();
      for (int k = 0; k < 30; k++) @(negedge clk);
      chk("held_no_accept_fb", 32'(feedback), 32'd0);
      chk("held_no_accept_score", 32'(score_l), 32'd0);
      joy_l = 4'hF;
      tick(3);
      sb.push_back(mk_e(2'b01, 3'd1, 3'd0, 1'b0, 1'b0));
      press(3'd2, 3'd0);
      chk("repress_score_l", 32'(score_l), 32'd1);
      chk("repress_q_idx", 32'(q_idx), 32'd1);

      // Full game of wrong answers with one skipped question.
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      pulse_start();
      for (int qi = 0; qi < 11; qi++) begin
         if (qi == 3) begin
            q_ans = 3'd0;
            tick(1);
            q_ans = 3'd1;
            tick(3);
            chk("aw_skip_scores", 32'({score_l, score_r}), 32'd0);
         end else begin
            q_ans = 3'd1;
            sb.push_back(mk_e(2'b10, 3'd0, 3'd0, 1'b1, 1'b0));
            press(3'd2, 3'd0);
            chk("aw_lock_l", 32'(lock_l), 32'd1);
            sb.push_back(mk_e(2'b10, 3'd0, 3'd0, 1'b1, 1'b1));
            press(3'd0, 3'd3);
            chk("aw_locks_cleared", 32'({lock_l, lock_r}), 32'd0);
         end
         chk("aw_q_idx", 32'(q_idx), (qi == 10) ? 32'd10 : 32'(qi + 1));
      end
      chk("aw_game_over", 32'(game_over), 32'd1);
      chk("aw_winner_tie", 32'(winner), 32'd3);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter NUM_Q, default 11, number of questions per game; q_idx runs 0..NUM_Q-1.
REQ-002 Parameter WIN_SCORE, default 5, score that ends the game; scores saturate here.
REQ-003 Parameter DEBOUNCE_CYC, default 4, consecutive stable synchronized cycles required to accept a press.
REQ-004 Parameter FEEDBACK_CYC, default 8, cycles spent in SHOW.
REQ-005 clk  in  1  single system clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  level sampled per cycle; starts or restarts a game.
REQ-008 joy_l  in  4  left joystick, active-low one-hot, 4'b1111 idle.
REQ-009 joy_r  in  4  right joystick, same encoding as joy_l.
REQ-010 q_ans  in  3  correct answer of current question, valid 1..4.
REQ-011 q_idx  out  4  current question index to the question ROM.
REQ-012 score_l, score_r  out  3 each  player scores, binary 0..WIN_SCORE.
REQ-013 feedback  out  2  00 none, 01 correct, 10 wrong; valid only in SHOW.
REQ-014 lock_l, lock_r  out  1 each  player locked out for the current question.
REQ-015 game_over  out  1  high only in DONE.
REQ-016 winner  out  2  00 none, 01 left, 10 right, 11 tie; nonzero only in DONE.

Function
REQ-017 Each joystick SHALL pass a 2-flop synchronizer; decode 1110->1, 1101->2, 1011->3, 0111->4; any other non-1111 pattern is invalid and ignored.
REQ-018 A press SHALL be accepted when the same valid code is held DEBOUNCE_CYC consecutive synchronized cycles and the player is armed; acceptance disarms the player; synchronized 1111 for one cycle re-arms.
REQ-019 States: IDLE, ASK, JUDGE, SHOW, NEXT, DONE; reset enters IDLE.
REQ-020 IDLE: start=1 -> ASK with q_idx=0, scores 0, locks 0.
REQ-021 ASK: if q_ans not in 1..4 -> NEXT directly (skipped question, no scoring); else wait for an accepted press from an unlocked player -> JUDGE.
REQ-022 Arbitration: first accepted press wins; presses from locked players or outside ASK are discarded (player still disarmed).
REQ-023 Same-cycle acceptance by both: alternating priority, left first after reset; priority bit toggles after each tie; loser's press discarded.
REQ-024 JUDGE (exactly 1 cycle): code==q_ans -> winner's score +1 (saturating at WIN_SCORE), feedback=01; else winner's lock set, feedback=10; -> SHOW.
REQ-025 Score update and lock SHALL be visible on the cycle after JUDGE.
REQ-026 SHOW: stay FEEDBACK_CYC cycles, then: correct -> NEXT; wrong with both locked -> NEXT; wrong with one locked -> ASK; feedback returns to 00 on exit.
REQ-027 NEXT (1 cycle): clear locks; if either score==WIN_SCORE or q_idx==NUM_Q-1 -> DONE; else q_idx+1 -> ASK.
REQ-028 DONE: game_over=1; winner = 01 if score_l>score_r, 10 if less, 11 if equal; outputs held; start=1 -> restart as REQ-020.
REQ-029 start SHALL be ignored in ASK, JUDGE, SHOW, NEXT.
REQ-030 q_idx SHALL never exceed NUM_Q-1; no wrap.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, q_idx=0, scores 0, feedback 00, locks 0, game_over 0, winner 00, tie priority left, synchronizers 1111, both players armed, counters 0, including mid-game.
REQ-032 After rst_n deassert, a joystick already held SHALL NOT be accepted until released (arming requires observed 1111).

Verification
REQ-033 start, q_ans=2, left holds 1101 -> JUDGE 2+DEBOUNCE_CYC cycles later, score_l=1, feedback=01 for 8 cycles, q_idx=1.
REQ-034 q_ans=3, left presses 1 -> lock_l=1, feedback=10, back to ASK; right presses 3 -> score_r=1, q_idx advances, locks cleared.
REQ-035 Both press correct code same cycle twice -> first tie scores left, second tie scores right.
REQ-036 Left answers correctly 5 times -> score_l=5, DONE, game_over=1, winner=01; start -> scores 0, q_idx 0.
REQ-037 All 11 questions both wrong -> DONE after q_idx=10, winner=11; q_ans=0 question skipped with no score change.
REQ-038 rst_n pulsed low in SHOW with joy_l held -> all outputs reset value immediately; no press accepted until joy_l released and re-pressed.
